// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory access controller: size codes,
// exception codes, FSM state encodings and the alignment check.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_INVADDR = 2'd1,
    EXC_ALOAD   = 2'd2,
    EXC_ASTORE  = 2'd3
  } exc_code_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Size code 3 behaves as a word access, so any size with bit 1 set is a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    if (size == SZ_BYTE)      return 1'b0;
    else if (size == SZ_HALF) return a[0];
    else                      return (a != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU request/response and RAM port bundle of the data-memory controller.
// slave = controller side, master = CPU plus RAM side.
interface data_mem_ctrl_if #(
  parameter int ADDR_W  = 13,
  parameter int WORD_AW = 11
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [1:0]         req_size;
  logic               req_signed;
  logic [ADDR_W-1:0]  phys_addr;
  logic               inv_addr;
  logic [31:0]        wdata;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               exc_valid;
  logic [1:0]         exc_code;
  logic               ram_en;
  logic [3:0]         ram_we;
  logic [WORD_AW-1:0] ram_addr;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, phys_addr, inv_addr, wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, exc_valid, exc_code,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, phys_addr, inv_addr, wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, exc_valid, exc_code,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/load_align.sv
// Load-data alignment: picks the addressed byte/half lane out of the RAM word
// and zero- or sign-extends it to 32 bits.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] result
);
  logic [31:0]        shifted;
  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  // Shift the addressed lane down to bit 0, then extend per size/signedness.
  // Halves are always 2-byte aligned here, so the same byte shift applies.
  always_comb begin
    shifted = rdata >> {a, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    result  = rdata;
    if (size == SZ_BYTE)
      result = {{24{sgn & lane_b[7]}}, lane_b};
    else if (size == SZ_HALF)
      result = {{16{sgn & lane_h[15]}}, lane_h};
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: alignment/invalid-address checking, byte-lane
// RAM writes, single outstanding RAM read and extended load response.
module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int WORD_AW = 11
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave mem
);
  state_t             state, state_nxt;
  logic               accept;
  logic               fault;
  exc_code_t          fault_code;
  logic               store_go;
  logic [3:0]         lane_be;
  logic [31:0]        ld_data;

  logic [1:0]         a_p0;
  logic [1:0]         size_p0;
  logic               sgn_p0;
  logic [WORD_AW-1:0] waddr_p0;
  exc_code_t          exc_code_p0;
  logic [31:0]        rsp_rdata_p2;

  // Request decode in the accept cycle; invalid address outranks misalignment.
  always_comb begin
    accept     = (state == ST_IDLE) & mem.req_valid & ~rst;
    fault_code = EXC_NONE;
    if (mem.inv_addr)
      fault_code = EXC_INVADDR;
    else if (is_misaligned(mem.req_size, mem.phys_addr[1:0]))
      fault_code = mem.req_write ? EXC_ASTORE : EXC_ALOAD;
    fault    = (fault_code != EXC_NONE);
    store_go = accept & ~fault & mem.req_write;
    if (mem.req_size == SZ_BYTE)      lane_be = 4'b0001 << mem.phys_addr[1:0];
    else if (mem.req_size == SZ_HALF) lane_be = 4'b0011 << mem.phys_addr[1:0];
    else                              lane_be = 4'hF;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = fault ? ST_FAULT : (mem.req_write ? ST_DONE : ST_ISSUE);
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      ST_FAULT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: stores hit the RAM in the accept cycle, loads read in ISSUE.
  always_comb begin
    mem.req_ready = (state == ST_IDLE);
    mem.rsp_valid = (state == ST_DONE);
    mem.exc_valid = (state == ST_FAULT);
    mem.ram_en    = store_go | (state == ST_ISSUE);
    mem.ram_we    = store_go ? lane_be : 4'h0;
    mem.ram_addr  = (state == ST_IDLE) ? mem.phys_addr[ADDR_W-1:2] : waddr_p0;
    if (mem.req_size == SZ_BYTE)      mem.ram_wdata = {4{mem.wdata[7:0]}};
    else if (mem.req_size == SZ_HALF) mem.ram_wdata = {2{mem.wdata[15:0]}};
    else                              mem.ram_wdata = mem.wdata;
  end

  load_align u_load_align (
    .rdata  (mem.ram_rdata),
    .a      (a_p0),
    .size   (size_p0),
    .sgn    (sgn_p0),
    .result (ld_data)
  );

  // Stage p0: latch request attributes at accept (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0     <= mem.phys_addr[1:0];
      size_p0  <= mem.req_size;
      sgn_p0   <= mem.req_signed;
      waddr_p0 <= mem.phys_addr[ADDR_W-1:2];
    end
  end

  // Stage p2: response data and exception code; both hold until overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_p2 <= '0;
      exc_code_p0  <= EXC_NONE;
    end else begin
      if (accept && fault) exc_code_p0 <= fault_code;
      if (accept && (fault || mem.req_write)) rsp_rdata_p2 <= '0;
      else if (state == ST_WAIT) rsp_rdata_p2 <= ld_data;
    end
  end

  assign mem.rsp_rdata = rsp_rdata_p2;
  assign mem.exc_code  = exc_code_p0;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural byte-enabled RAM.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(13), .WORD_AW(11)) bus ();

  data_mem_ctrl #(.ADDR_W(13), .WORD_AW(11)) dut (
    .clk (clk),
    .rst (rst),
    .mem (bus.slave)
  );

  // Synchronous RAM: read data appears one cycle after ram_en with ram_we=0.
  logic [31:0] ram [0:2047];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we == 4'h0) bus.ram_rdata <= ram[bus.ram_addr];
      for (int i = 0; i < 4; i++)
        if (bus.ram_we[i]) ram[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [12:0] addr;
    logic        inv;
    logic [31:0] wdata;
    logic        is_exc;
    logic [31:0] rdata;
    logic [1:0]  code;
    logic [3:0]  we;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    logic en_seen;
    logic en_issue;
    @(negedge clk);
    bus.req_write  = v.wr;
    bus.req_size   = v.size;
    bus.req_signed = v.sgn;
    bus.phys_addr  = v.addr;
    bus.inv_addr   = v.inv;
    bus.wdata      = v.wdata;
    bus.req_valid  = 1'b1;
    #1;
    chk($sformatf("v%0d ready", idx), 32'(bus.req_ready), 32'd1);
    chk($sformatf("v%0d accept_we", idx), 32'(bus.ram_we), 32'(v.we));
    chk($sformatf("v%0d accept_en", idx), 32'(bus.ram_en), 32'(v.we != 4'h0));
    if (v.wr && !v.is_exc) chk($sformatf("v%0d wdata", idx), bus.ram_wdata, v.wd);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    en_seen = bus.ram_en;
    en_issue = bus.ram_en;
    while (!(bus.rsp_valid || bus.exc_valid) && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      en_seen |= bus.ram_en;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), (v.is_exc || v.wr) ? 32'd1 : 32'd3);
    chk($sformatf("v%0d rsp_valid", idx), 32'(bus.rsp_valid), 32'(!v.is_exc));
    chk($sformatf("v%0d exc_valid", idx), 32'(bus.exc_valid), 32'(v.is_exc));
    if (v.is_exc) begin
      chk($sformatf("v%0d exc_code", idx), 32'(bus.exc_code), 32'(v.code));
      chk($sformatf("v%0d fault_ram_en", idx), 32'(en_seen), 32'd0);
    end else begin
      chk($sformatf("v%0d rdata", idx), bus.rsp_rdata, v.rdata);
      if (!v.wr) chk($sformatf("v%0d issue_en", idx), 32'(en_issue), 32'd1);
    end
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    ram[1] = 32'hDEADBEEF;
    bus.ram_rdata  = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.phys_addr  = 13'h0;
    bus.inv_addr   = 1'b0;
    bus.wdata      = 32'h0;

    //            wr    size  sgn   addr      inv   wdata         exc   rdata         code  we       wd
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 13'h0004, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 2'd0, 4'h0,    32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 13'h0007, 1'b0, 32'h0,        1'b0, 32'hFFFFFFDE, 2'd0, 4'h0,    32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 13'h0007, 1'b0, 32'h0,        1'b0, 32'h000000DE, 2'd0, 4'h0,    32'h0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 13'h0006, 1'b0, 32'h0,        1'b0, 32'hFFFFDEAD, 2'd0, 4'h0,    32'h0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 13'h0004, 1'b0, 32'h0,        1'b0, 32'h0000BEEF, 2'd0, 4'h0,    32'h0};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 13'h0005, 1'b0, 32'h0,        1'b0, 32'hFFFFFFBE, 2'd0, 4'h0,    32'h0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 13'h0002, 1'b0, 32'h000000AB, 1'b0, 32'h0,        2'd0, 4'b0100, 32'hABABABAB};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 13'h0008, 1'b0, 32'h12345678, 1'b0, 32'h0,        2'd0, 4'hF,    32'h12345678};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 13'h000A, 1'b0, 32'h0000CAFE, 1'b0, 32'h0,        2'd0, 4'b1100, 32'hCAFECAFE};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 13'h0008, 1'b0, 32'h0,        1'b0, 32'hCAFE5678, 2'd0, 4'h0,    32'h0};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 13'h0002, 1'b0, 32'h0,        1'b1, 32'h0,        2'd2, 4'h0,    32'h0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 13'h0001, 1'b0, 32'h00001234, 1'b1, 32'h0,        2'd3, 4'h0,    32'h0};
    vecs[12] = '{1'b0, 2'd1, 1'b1, 13'h0003, 1'b0, 32'h0,        1'b1, 32'h0,        2'd2, 4'h0,    32'h0};
    vecs[13] = '{1'b1, 2'd2, 1'b0, 13'h0000, 1'b1, 32'h55555555, 1'b1, 32'h0,        2'd1, 4'h0,    32'h0};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 13'h0000, 1'b0, 32'h0,        1'b0, 32'h00AB0000, 2'd0, 4'h0,    32'h0};
    vecs[15] = '{1'b0, 2'd3, 1'b1, 13'h0004, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 2'd0, 4'h0,    32'h0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst exc_valid", 32'(bus.exc_valid), 32'd0);
    chk("rst ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst exc_code", 32'(bus.exc_code), 32'd0);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Response data and exception code hold after their pulses end.
    @(negedge clk);
    chk("hold exc_code", 32'(bus.exc_code), 32'd1);
    chk("hold rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);

    // Reset while the load waits for RAM data: access aborted, no response.
    @(negedge clk);
    bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.phys_addr = 13'h0004; bus.inv_addr = 1'b0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("abort exc_code", 32'(bus.exc_code), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort quiet%0d", i), 32'({bus.rsp_valid, bus.exc_valid}), 32'd0);
    end
    chk("abort rdata_after", bus.rsp_rdata, 32'd0);

    // Controller still works after the aborted access.
    run_vec(16, vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
